// File: rtl/vga_sync_if.sv
// Sync-decoder bus: raw hsync/vsync and window configuration in, recovered
// coordinates, strobes, measured totals and lock status out.
interface vga_sync_if #(
   parameter int xresolution = 10,
   parameter int yresolution = 10
);
   logic                   hsync;
   logic                   vsync;
   logic [xresolution-1:0] HBackPorch;
   logic [xresolution-1:0] HActive;
   logic [yresolution-1:0] VBackPorch;
   logic [yresolution-1:0] VActive;

   logic [xresolution-1:0] xposition;
   logic [yresolution-1:0] yposition;
   logic                   DataEnable;
   logic                   LineStart;
   logic                   FrameStart;
   logic [xresolution-1:0] HTotal;
   logic [yresolution-1:0] VTotal;
   logic                   Locked;

   modport master (
      output hsync, vsync, HBackPorch, HActive, VBackPorch, VActive,
      input  xposition, yposition, DataEnable, LineStart, FrameStart,
             HTotal, VTotal, Locked
   );

   modport slave (
      input  hsync, vsync, HBackPorch, HActive, VBackPorch, VActive,
      output xposition, yposition, DataEnable, LineStart, FrameStart,
             HTotal, VTotal, Locked
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, data-enable, line/frame totals and a lock flag
// from active-low hsync/vsync, one pixel per clock.
module vga_sync_decoder #(
   parameter int xresolution = 10,
   parameter int yresolution = 10
) (
   input  logic     Clock,
   input  logic     Reset,
   vga_sync_if.slave bus
);

   typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

   localparam logic [xresolution-1:0] HMAX = '1;
   localparam logic [yresolution-1:0] VMAX = '1;

   state_t                 state, state_next;
   logic                   hs_d, vs_line;
   logic                   hseen, frame_seen, line_err;
   logic [xresolution-1:0] hcount, htotal, hlen;
   logic [yresolution-1:0] vcount, vtotal, vlen;
   logic                   hrise, restart, hsat, err_set, err_any, good;
   logic                   hact, vact, locked, de;
   logic [xresolution:0]   hend;
   logic [yresolution:0]   vend;

   assign hrise   = bus.hsync & ~hs_d;
   assign restart = hrise & bus.vsync & ~vs_line;
   assign hsat    = (hcount == HMAX) & ~hrise;
   assign hlen    = hcount + 1'b1;
   assign vlen    = vcount + 1'b1;
   assign err_set = hrise & hseen & (htotal != '0) & (hlen != htotal);
   // A mismatch on the closing edge itself must count, not just earlier ones.
   assign err_any = line_err | err_set;
   assign good    = frame_seen & ~err_any & (vlen == vtotal);

   always_ff @(posedge Clock) begin
      if (Reset) state <= HUNT;
      else       state <= state_next;
   end

   // NOTE: next state defaults to the current one so no path infers a latch.
   always_comb begin
      state_next = state;
      if (restart) begin
         unique case (state)
            HUNT:    state_next = (frame_seen & ~err_any) ? CHECK : HUNT;
            CHECK:   state_next = good ? LOCKED : HUNT;
            LOCKED:  state_next = good ? LOCKED : HUNT;
            default: state_next = HUNT;
         endcase
      end else if (hsat) begin
         state_next = HUNT;
      end else if ((state == LOCKED) && err_any) begin
         state_next = HUNT;
      end
   end

   // NOTE: all state updates are non-blocking so every branch sees pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         hs_d       <= 1'b1;
         vs_line    <= 1'b1;
         hcount     <= '0;
         vcount     <= '0;
         htotal     <= '0;
         vtotal     <= '0;
         hseen      <= 1'b0;
         frame_seen <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         hs_d <= bus.hsync;
         if (hrise) begin
            hcount  <= '0;
            hseen   <= 1'b1;
            vs_line <= bus.vsync;
            if (hseen) htotal <= hlen;
            if (restart) begin
               vcount     <= '0;
               frame_seen <= 1'b1;
               line_err   <= 1'b0;
               if (frame_seen) vtotal <= vlen;
            end else begin
               if (vcount != VMAX) vcount <= vlen;
               if (err_set) line_err <= 1'b1;
            end
         end else if (hsat) begin
            // Lost horizontal sync: forget everything measured so far.
            hseen      <= 1'b0;
            frame_seen <= 1'b0;
         end else begin
            hcount <= hlen;
         end
      end
   end

   assign hend   = {1'b0, bus.HBackPorch} + {1'b0, bus.HActive};
   assign vend   = {1'b0, bus.VBackPorch} + {1'b0, bus.VActive};
   assign hact   = (hcount >= bus.HBackPorch) && ({1'b0, hcount} < hend);
   assign vact   = (vcount >= bus.VBackPorch) && ({1'b0, vcount} < vend);
   assign locked = (state == LOCKED);
   assign de     = hact & vact & locked;

   assign bus.LineStart  = hrise;
   assign bus.FrameStart = restart;
   assign bus.HTotal     = htotal;
   assign bus.VTotal     = vtotal;
   assign bus.Locked     = locked;
   assign bus.DataEnable = de;
   assign bus.xposition  = de ? hcount - bus.HBackPorch : '0;
   assign bus.yposition  = de ? vcount - bus.VBackPorch : '0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: timestamp-based reference model checked every
// cycle, plus directed frame-level checks on lock timing and windowing.
module tb_vga_sync_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_sync_if #(.xresolution(10), .yresolution(10)) bus ();

   vga_sync_decoder #(.xresolution(10), .yresolution(10)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: line start times and line/frame counts as plain integers
   bit m_valid = 0;
   int m_edge = 0, m_href = 0;
   bit m_hs_prev, m_hseen, m_lerr, m_vsl, m_fseen;
   int m_htot, m_vc, m_vtot, m_stage;

   // observed frame-level statistics
   int cyc = 0, fs_count, fs_prev_cyc, fs_period, de_count, ls_count, lock_fs;
   int first_x, first_y, last_x, last_y;
   bit de_first, prev_locked;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int hc_now();
      int d;
      d = m_edge - m_href;
      return (d > 1023) ? 1023 : d;
   endfunction

   task automatic model_update(input bit h, input bit v, input bit r);
      int hc, len;
      bit rise, err_now, bad, good;
      hc = hc_now();
      m_edge++;
      if (r) begin
         m_valid = 1; m_href = m_edge; m_hs_prev = 1; m_hseen = 0; m_htot = 0;
         m_lerr = 0; m_vsl = 1; m_vc = 0; m_fseen = 0; m_vtot = 0; m_stage = 0;
         return;
      end
      rise = h && !m_hs_prev;
      if (rise) begin
         len = (hc + 1) % 1024;
         err_now = m_hseen && (m_htot != 0) && (len != m_htot);
         if (v && !m_vsl) begin
            bad  = m_lerr || err_now;
            good = m_fseen && !bad && (((m_vc + 1) % 1024) == m_vtot);
            if (m_stage == 0) m_stage = (m_fseen && !bad) ? 1 : 0;
            else              m_stage = good ? 2 : 0;
            if (m_fseen) m_vtot = (m_vc + 1) % 1024;
            m_fseen = 1; m_lerr = 0; m_vc = 0;
         end else begin
            if (m_stage == 2 && (m_lerr || err_now)) m_stage = 0;
            if (err_now) m_lerr = 1;
            if (m_vc < 1023) m_vc++;
         end
         if (m_hseen) m_htot = len;
         m_hseen = 1; m_vsl = v; m_href = m_edge;
      end else if (hc == 1023) begin
         m_stage = 0; m_hseen = 0; m_fseen = 0;
      end else if (m_stage == 2 && m_lerr) begin
         m_stage = 0;
      end
      m_hs_prev = h;
   endtask

   task automatic check_outputs(input bit h, input bit v);
      int hc, hb, vb;
      bit ls, hin, vin, de;
      hc  = hc_now();
      hb  = int'(bus.HBackPorch);
      vb  = int'(bus.VBackPorch);
      ls  = h && !m_hs_prev;
      hin = (hc >= hb) && (hc < hb + int'(bus.HActive));
      vin = (m_vc >= vb) && (m_vc < vb + int'(bus.VActive));
      de  = hin && vin && (m_stage == 2);
      check("LineStart",  bus.LineStart,  ls);
      check("FrameStart", bus.FrameStart, ls && v && !m_vsl);
      check("Locked",     bus.Locked,     m_stage == 2);
      check("DataEnable", bus.DataEnable, de);
      check("xposition",  bus.xposition,  de ? hc - hb : 0);
      check("yposition",  bus.yposition,  de ? m_vc - vb : 0);
      check("HTotal",     bus.HTotal,     m_htot);
      check("VTotal",     bus.VTotal,     m_vtot);
   endtask

   task automatic clear_stats();
      fs_count = 0; fs_prev_cyc = -1; fs_period = 0; de_count = 0; ls_count = 0;
      lock_fs = -1; de_first = 0; prev_locked = (bus.Locked === 1'b1);
   endtask

   task automatic collect_stats();
      if (bus.FrameStart === 1'b1) begin
         fs_count++;
         if (fs_prev_cyc >= 0) fs_period = cyc - fs_prev_cyc;
         fs_prev_cyc = cyc;
      end
      if (bus.LineStart === 1'b1) ls_count++;
      if (bus.DataEnable === 1'b1) begin
         de_count++;
         if (!de_first) begin
            de_first = 1; first_x = int'(bus.xposition); first_y = int'(bus.yposition);
         end
         last_x = int'(bus.xposition); last_y = int'(bus.yposition);
      end
      if (bus.Locked === 1'b1 && !prev_locked && lock_fs < 0) lock_fs = fs_count;
      prev_locked = (bus.Locked === 1'b1);
   endtask

   task automatic step(input bit h, input bit v, input bit r);
      @(negedge clk);
      bus.hsync = h; bus.vsync = v; rst = r;
      #1;
      if (m_valid) check_outputs(h, v);
      collect_stats();
      @(posedge clk);
      model_update(h, v, r);
      cyc++;
   endtask

   task automatic check_reset_zero(input string tag);
      check({tag, "_Locked"},     bus.Locked,     0);
      check({tag, "_DataEnable"}, bus.DataEnable, 0);
      check({tag, "_LineStart"},  bus.LineStart,  0);
      check({tag, "_FrameStart"}, bus.FrameStart, 0);
      check({tag, "_HTotal"},     bus.HTotal,     0);
      check({tag, "_VTotal"},     bus.VTotal,     0);
      check({tag, "_xposition"},  bus.xposition,  0);
      check({tag, "_yposition"},  bus.yposition,  0);
   endtask

   // Line order Active-FrontPorch-Sync(3)-BackPorch(4); frame ends with Sync(2)-BackPorch(2).
   task automatic frame(input int nlines, input int short_idx, input int short_len,
                        input int rst_at);
      int c, len;
      bit h, v;
      c = 0;
      for (int l = 0; l < nlines; l++) begin
         len = (l == short_idx) ? short_len : 25;
         v   = !(l == nlines - 4 || l == nlines - 3);
         for (int x = 0; x < len; x++) begin
            h = !(x >= len - 7 && x < len - 4);
            if (c == rst_at) begin
               step(h, v, 1);
               #1;
               check_reset_zero("midreset");
               clear_stats();
            end else begin
               step(h, v, 0);
            end
            c++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.hsync = 1'b1; bus.vsync = 1'b1; rst = 1'b1;
      bus.HBackPorch = 10'd4; bus.HActive = 10'd16;
      bus.VBackPorch = 10'd2; bus.VActive = 10'd6;

      repeat (3) step(1, 1, 1);
      #1;
      check_reset_zero("reset");

      // Acquire lock from reset
      clear_stats();
      repeat (4) frame(11, -1, 25, -1);
      check("lock_after_restarts", lock_fs, 3);
      check("frame_period", fs_period, 275);
      check("HTotal_locked", bus.HTotal, 25);
      check("VTotal_locked", bus.VTotal, 11);
      check("Locked_steady", bus.Locked, 1);

      // Active window inside a locked frame
      clear_stats();
      frame(11, -1, 25, -1);
      check("de_count", de_count, 96);
      check("first_x", first_x, 0);
      check("first_y", first_y, 0);
      check("last_x", last_x, 15);
      check("last_y", last_y, 5);

      // One line shortened to 24 clocks
      clear_stats();
      frame(11, int'($urandom_range(0, 6)), 24, -1);
      check("short_line_unlocked", bus.Locked, 0);
      repeat (3) frame(11, -1, 25, -1);
      check("short_line_relock", lock_fs, 3);

      // hsync stuck high long enough to saturate
      clear_stats();
      n = 1030 + int'($urandom_range(0, 170));
      repeat (n) step(1, 1, 0);
      check("stall_linestarts", ls_count, 0);
      check("stall_de", de_count, 0);
      check("stall_locked", bus.Locked, 0);
      clear_stats();
      repeat (4) frame(11, -1, 25, -1);
      check("stall_relock", lock_fs, 3);

      // Reset pulse at a random point of a locked frame
      frame(11, -1, 25, int'($urandom_range(0, 274)));
      repeat (4) frame(11, -1, 25, -1);
      check("reset_relock", lock_fs, 3);

      // Frame height grows to 12 lines
      clear_stats();
      frame(12, -1, 25, -1);
      check("vchange_unlocked", bus.Locked, 0);
      check("vchange_VTotal", bus.VTotal, 12);
      repeat (3) frame(12, -1, 25, -1);
      check("vchange_relock", lock_fs, 3);
      check("vchange_VTotal_final", bus.VTotal, 12);

      // Random sync noise with random window settings
      for (int k = 0; k < 4; k++) begin
         bit h, v;
         h = 1; v = 1;
         bus.HBackPorch = 10'($urandom_range(0, 30));
         bus.HActive    = 10'($urandom_range(1, 40));
         bus.VBackPorch = 10'($urandom_range(0, 4));
         bus.VActive    = 10'($urandom_range(1, 8));
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) h = ~h;
            if ($urandom_range(0, 9) == 0) v = ~v;
            step(h, v, ($urandom_range(0, 199) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
